// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-register bridge.
// Header layout, FSM states and parameter legality helper.
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        WR_DATA,
        RD_FETCH,
        RD_DATA
    } state_t;

    localparam int HDR_WR_BIT    = 7;
    localparam int HDR_INC_BIT   = 6;
    localparam int HDR_ADDR_LSBS = 6;

    function automatic bit params_ok(int aw, int dw);
        return (aw >= 6) && (aw <= 14) &&
               (dw >= 8) && (dw <= 32) && (dw % 8 == 0);
    endfunction

endpackage

// File: rtl/spi_word_buf.sv
// Word shift register: assembles write words MSB byte first,
// serialises read words and flags the final byte of a word.
module spi_word_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_word,
    input  logic              push,
    input  logic              pop,
    input  logic [7:0]        data_in,
    output logic [DATA_W-1:0] next_word,
    output logic [7:0]        next_top,
    output logic              last,
    output logic              busy
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] word;
    logic [2:0]        cnt;

    assign next_word = DATA_W'({word, data_in});
    assign next_top  = 8'(DATA_W'({word, 8'h00}) >> (DATA_W - 8));
    assign last      = (cnt == 3'(NB - 1));
    assign busy      = (cnt != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= 3'd0;
        end else if (clear) begin
            cnt <= 3'd0;
        end else if (load) begin
            word <= load_word;
            cnt  <= 3'd0;
        end else if (push || pop) begin
            word <= push ? next_word : DATA_W'({word, 8'h00});
            cnt  <= last ? 3'd0 : cnt + 3'd1;
        end
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// Bridge from SPI slave byte stream to register strobes,
// with multi-byte words and auto-incrementing bursts.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_active,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_read,
    output logic [DATA_W-1:0] data_write,
    output logic              frame_err
);

    if (!params_ok(ADDR_W, DATA_W)) begin : g_bad_params
        $error("spi_reg_bridge: illegal ADDR_W/DATA_W");
    end

    state_t            state;
    logic              is_wr;
    logic              incr;
    logic              armed;
    logic [DATA_W-1:0] next_word;
    logic [7:0]        next_top;
    logic              last;
    logic              busy;

    spi_word_buf #(.DATA_W(DATA_W)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (!frame_active),
        .load      (frame_active && state == RD_FETCH),
        .load_word (data_read),
        .push      (frame_active && byte_sync && state == WR_DATA),
        .pop       (frame_active && byte_sync && state == RD_DATA),
        .data_in   (data_in),
        .next_word (next_word),
        .next_top  (next_top),
        .last      (last),
        .busy      (busy)
    );

    // armed blocks decoding of a frame already in flight at reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            is_wr      <= 1'b0;
            incr       <= 1'b0;
            armed      <= 1'b0;
            addr       <= '0;
            data_write <= '0;
            data_out   <= 8'h00;
            read       <= 1'b0;
            write      <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            read      <= 1'b0;
            write     <= 1'b0;
            frame_err <= 1'b0;
            if (write && incr)
                addr <= addr + ADDR_W'(1);
            if (!frame_active) begin
                armed <= 1'b1;
                if (state != IDLE) begin
                    frame_err <= (state == ADDR_HI) ||
                                 (state == WR_DATA && busy);
                    state     <= IDLE;
                end
            end else begin
                unique case (state)
                    IDLE: if (byte_sync && armed) begin
                        is_wr <= data_in[HDR_WR_BIT];
                        incr  <= data_in[HDR_INC_BIT];
                        addr  <= ADDR_W'(data_in[HDR_ADDR_LSBS-1:0]);
                        if (ADDR_W > HDR_ADDR_LSBS) begin
                            state <= ADDR_HI;
                        end else if (data_in[HDR_WR_BIT]) begin
                            state <= WR_DATA;
                        end else begin
                            state <= RD_FETCH;
                            read  <= 1'b1;
                        end
                    end
                    ADDR_HI: if (byte_sync) begin
                        addr <= ADDR_W'({data_in,
                                         addr[HDR_ADDR_LSBS-1:0]});
                        if (is_wr) begin
                            state <= WR_DATA;
                        end else begin
                            state <= RD_FETCH;
                            read  <= 1'b1;
                        end
                    end
                    WR_DATA: if (byte_sync && last) begin
                        write      <= 1'b1;
                        data_write <= next_word;
                    end
                    RD_FETCH: begin
                        data_out <= 8'(data_read >> (DATA_W - 8));
                        state    <= RD_DATA;
                    end
                    RD_DATA: if (byte_sync) begin
                        if (last) begin
                            state <= RD_FETCH;
                            read  <= 1'b1;
                            if (incr)
                                addr <= addr + ADDR_W'(1);
                        end else begin
                            data_out <= next_top;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: 6/16 and 10/32 instances
// on a shared SPI byte bus, strobes logged at the falling edge.
module tb_spi_reg_bridge;

    logic        clk = 1'b0;
    logic        rst16_n = 1'b0;
    logic        rst10_n = 1'b0;
    logic        frame_active = 1'b0;
    logic        byte_sync = 1'b0;
    logic [7:0]  data_in = 8'h00;

    logic [7:0]  do16, do10;
    logic        r16, w16, e16, r10, w10, e10;
    logic [5:0]  a16;
    logic [9:0]  a10;
    logic [15:0] dw16;
    logic [31:0] dw10;
    logic [15:0] dr16;
    logic [31:0] dr10;

    int n_tests = 0;
    int n_fail  = 0;
    int err16 = 0, err10 = 0, overlap = 0;
    logic [63:0] wq16[$];
    logic [63:0] rq16[$];
    logic [63:0] wq10[$];

    always #5 clk = ~clk;

    assign dr16 = {2{{2'b00, a16}}};
    assign dr10 = 32'h0;

    spi_reg_bridge #(.ADDR_W(6), .DATA_W(16)) u16 (
        .clk(clk), .rst_n(rst16_n), .frame_active(frame_active),
        .byte_sync(byte_sync), .data_in(data_in), .data_out(do16),
        .read(r16), .write(w16), .addr(a16), .data_read(dr16),
        .data_write(dw16), .frame_err(e16)
    );

    spi_reg_bridge #(.ADDR_W(10), .DATA_W(32)) u10 (
        .clk(clk), .rst_n(rst10_n), .frame_active(frame_active),
        .byte_sync(byte_sync), .data_in(data_in), .data_out(do10),
        .read(r10), .write(w10), .addr(a10), .data_read(dr10),
        .data_write(dw10), .frame_err(e10)
    );

    always @(negedge clk) begin
        if (w16) wq16.push_back(64'({a16, dw16}));
        if (r16) rq16.push_back(64'(a16));
        if (e16) err16++;
        if (w10) wq10.push_back(64'({a10, dw10}));
        if (e10) err10++;
        if ((r16 && w16) || (r10 && w10)) overlap++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] shifted);
        @(negedge clk);
        shifted   = do16;
        data_in   = b;
        byte_sync = 1'b1;
        @(negedge clk);
        byte_sync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_start();
        @(negedge clk);
        frame_active = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        frame_active = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        logic [7:0] dummy;
        frame_start();
        foreach (bytes[i]) send_byte(bytes[i], dummy);
        frame_end();
    endtask

    initial begin
        int wb, rb, eb;
        logic [7:0] outs[4];
        logic [7:0] dummy;

        repeat (3) @(negedge clk);
        check("reset16", 64'({r16, w16, e16, a16, dw16, do16}), 64'd0);
        check("reset10", 64'({r10, w10, e10, a10, dw10, do10}), 64'd0);
        rst16_n = 1'b1;
        rst10_n = 1'b1;
        repeat (3) @(negedge clk);

        wb = wq16.size(); rb = rq16.size();
        send_frame('{8'h85, 8'h12, 8'h34});
        check("wr1_cnt", 64'(wq16.size() - wb), 64'd1);
        check("wr1", wq16[wb], 64'({6'd5, 16'h1234}));
        check("wr1_noread", 64'(rq16.size() - rb), 64'd0);

        wb = wq16.size();
        send_frame('{8'hC2, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
        check("inc_cnt", 64'(wq16.size() - wb), 64'd2);
        check("inc_w0", wq16[wb], 64'({6'd2, 16'hAABB}));
        check("inc_w1", wq16[wb+1], 64'({6'd3, 16'hCCDD}));

        wb = wq16.size();
        send_frame('{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04});
        check("wrap_cnt", 64'(wq16.size() - wb), 64'd2);
        check("wrap_w0", wq16[wb], 64'({6'd63, 16'h0102}));
        check("wrap_w1", wq16[wb+1], 64'({6'd0, 16'h0304}));

        wb = wq16.size(); rb = rq16.size();
        frame_start();
        send_byte(8'h50, dummy);
        for (int i = 0; i < 4; i++) send_byte(8'hA5, outs[i]);
        frame_end();
        check("rd_cnt", 64'(rq16.size() - rb), 64'd3);
        check("rd_a0", rq16[rb], 64'd16);
        check("rd_a1", rq16[rb+1], 64'd17);
        check("rd_a2", rq16[rb+2], 64'd18);
        check("rd_do0", 64'(outs[0]), 64'h10);
        check("rd_do1", 64'(outs[1]), 64'h10);
        check("rd_do2", 64'(outs[2]), 64'h11);
        check("rd_do3", 64'(outs[3]), 64'h11);
        check("rd_nowrite", 64'(wq16.size() - wb), 64'd0);

        wb = wq16.size(); eb = err16;
        send_frame('{8'h85, 8'h12});
        check("abort_err", 64'(err16 - eb), 64'd1);
        check("abort_nowr", 64'(wq16.size() - wb), 64'd0);
        send_frame('{8'h85, 8'hAB, 8'hCD});
        check("after_cnt", 64'(wq16.size() - wb), 64'd1);
        check("after_w", wq16[wb], 64'({6'd5, 16'hABCD}));
        check("after_err", 64'(err16 - eb), 64'd1);

        wb = wq10.size();
        send_frame('{8'h81, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
        check("w32_cnt", 64'(wq10.size() - wb), 64'd1);
        check("w32", wq10[wb], 64'({10'h0C1, 32'hDEADBEEF}));

        wb = wq10.size(); eb = err10;
        frame_start();
        send_byte(8'h81, dummy);
        send_byte(8'h03, dummy);
        send_byte(8'hDE, dummy);
        send_byte(8'hAD, dummy);
        #2 rst10_n = 1'b0;
        @(negedge clk);
        check("rst_mid", 64'({r10, w10, e10, a10, dw10, do10}),
              64'({3'b000, 10'h0C1 & 10'h0, 32'h0, 8'h0}));
        rst10_n = 1'b1;
        send_byte(8'hBE, dummy);
        send_byte(8'hEF, dummy);
        frame_end();
        check("rst_nowr", 64'(wq10.size() - wb), 64'd0);
        check("rst_noerr", 64'(err10 - eb), 64'd0);

        check("no_overlap", 64'(overlap), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
